ks_multiword_sequencer: RTL and testbench
=========================================

# ks_multiword_sequencer

Initiator for the registered Kogge-Stone adder top (`KG_TOP`, 32-bit operands, 33-bit registered sum, two-edge latency). Accepts one wide add over a valid/ready handshake and splits it into DATA_WIDTH-bit words, least-significant word first. It feeds each word to the adder and chains each word's carry-out into the next word's carry-in. It reassembles the sum and returns the wide result with the final carry over a second valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, adder word width; must match the adder's DATA_WIDTH
- WORDS, 4, words per wide operand (≥2)
- LAT, 2, clock edges from add_* inputs to valid add_s; matches the adder's in/out DFF pair

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  wide request valid
- in_ready  out  1  request accepted on in_valid & in_ready
- in_a  in  DATA_WIDTH*WORDS  operand A
- in_b  in  DATA_WIDTH*WORDS  operand B
- in_cin  in  1  initial carry-in
- in_sub  in  1  subtract request (see Configuration)
- add_a  out  DATA_WIDTH  to adder A
- add_b  out  DATA_WIDTH  to adder B
- add_cin  out  1  to adder Cin
- add_s  in  DATA_WIDTH+1  from adder S; bit DATA_WIDTH is the carry
- out_valid  out  1  result valid
- out_ready  in  1  result consumed on out_valid & out_ready
- out_sum  out  DATA_WIDTH*WORDS  wide sum
- out_cout  out  1  final carry-out

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch in_a, in_b, the initial carry and in_sub.
  - Set word index k=0 and drive word 0 on add_*.
  - Go to ISSUE.
- ISSUE:
  - add_* hold word k.
  - Load wait counter with LAT-1.
  - Go to WAIT.
- WAIT:
  - Count down to 0.
  - At 0, add_s is valid. On that edge, write add_s[DATA_WIDTH-1:0] into out_sum word k.
  - If k<WORDS-1: k+1 → k, drive word k+1 with add_cin = add_s[DATA_WIDTH], go to ISSUE.
  - Otherwise: out_cout = add_s[DATA_WIDTH], go to DONE.
- DONE:
  - out_valid=1.
  - out_sum and out_cout are held stable until out_ready.
  - On handshake, go to IDLE.
- No overlap between requests: in_ready=0 in ISSUE, WAIT and DONE.
- add_a, add_b, add_cin, out_sum and out_cout are registered outputs, stable within a cycle.
- Arithmetic: out_sum equals in_a + in_b + cin modulo 2^(DATA_WIDTH*WORDS). out_cout is bit DATA_WIDTH*WORDS of the exact sum.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, add_a=0, add_b=0, add_cin=0, out_sum=0, out_cout=0, k=0.
- Accept edge ends cycle 0. Word k is presented in cycle 1+k(LAT+1) and captured at the end of cycle 1+k(LAT+1)+LAT.
- out_valid first rises in cycle 1+WORDS(LAT+1). With the defaults, that is cycle 13.
- Word period: LAT+1 cycles.
- in_valid while busy: ignored and not latched; the requester holds it.
- out_valid with out_ready=0: state holds indefinitely; no data change.
- Reset mid-operation: immediate return to reset values and the partial result is discarded. The adder shares rst, so its pipeline is cleared too. The first accept after reset release is legal in the first cycle.
- DONE handshake: in_ready rises the cycle after the out handshake. There is no same-cycle turnaround.

## Configuration
- Macro: `KS_MWSEQ_SUB_EN`.
- Defined:
  - When the accepted in_sub=1, every add_b word is ~in_b word and the initial carry is forced to 1 (in_cin ignored).
  - Result: out_sum = in_a − in_b mod 2^(DATA_WIDTH*WORDS).
  - out_cout=1 means no borrow.
  - When in_sub=0, behaviour is plain addition.
- Undefined:
  - in_sub is ignored and no inversion logic is built.
  - Behaviour always equals addition with in_cin.

## Test plan
- Full ripple: in_a=2^128−1, in_b=0, in_cin=1 → out_sum=0, out_cout=1; add_cin=1 on words 1–3.
- Single-word carry: in_a=0xFFFFFFFF, in_b=1, in_cin=0 → out_sum=0x1_00000000, out_cout=0; out_valid in cycle 13 after accept.
- Backpressure: out_ready held 0 for 5 cycles after out_valid → out_sum and out_cout stable, in_ready=0. A new in_valid during the stall is not accepted. Result released on the first out_ready=1.
- Reset mid-op: assert rst in cycle 6 of an add → out_valid=0, in_ready=1, add_*=0 immediately. Then 0x5+0x7 completes with out_sum=0xC.
- Subtract (`KS_MWSEQ_SUB_EN` defined): in_a=5, in_b=7, in_sub=1 → out_sum=2^128−2, out_cout=0. With in_a=7, in_b=5 → out_sum=2, out_cout=1.
- Back-to-back: two requests with in_valid held high → the second accept occurs exactly 1 cycle after the first out handshake; both results are correct.

Source files
------------

// File: rtl/ks_multiword_sequencer_if.sv
// Request/response bundle between a wide-add requester and ks_multiword_sequencer.
// master drives the request and consumes the result; slave is the sequencer side.
interface ks_multiword_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*WORDS-1:0] in_a;
    logic [DATA_WIDTH*WORDS-1:0] in_b;
    logic                        in_cin;
    logic                        in_sub;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*WORDS-1:0] out_sum;
    logic                        out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/ks_multiword_sequencer.sv
// Splits a wide add into DATA_WIDTH words for a registered Kogge-Stone adder, rippling carry.
// Optional subtract support is built when KS_MWSEQ_SUB_EN is defined.
module ks_multiword_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 4,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ks_multiword_sequencer_if.slave bus,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_cin,
    input  logic [DATA_WIDTH:0]   add_s
);
    localparam int W  = DATA_WIDTH * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [KW-1:0]   k;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    b_in;
    logic            cin_in;

`ifdef KS_MWSEQ_SUB_EN
    // Subtraction is a + ~b + 1, so invert once at accept time.
    assign b_in   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_in = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    logic unused_sub;
    assign unused_sub = bus.in_sub;
    assign b_in       = bus.in_b;
    assign cin_in     = bus.in_cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            k             <= '0;
            cnt           <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_cin       <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.in_a;
                        b_q          <= b_in;
                        k            <= '0;
                        add_a        <= bus.in_a[DATA_WIDTH-1:0];
                        add_b        <= b_in[DATA_WIDTH-1:0];
                        add_cin      <= cin_in;
                        bus.in_ready <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.out_sum[int'(k)*DATA_WIDTH +: DATA_WIDTH]
                            <= add_s[DATA_WIDTH-1:0];
                        if (k != KW'(WORDS - 1)) begin
                            k       <= k + 1'b1;
                            add_a   <= a_q[(int'(k)+1)*DATA_WIDTH +: DATA_WIDTH];
                            add_b   <= b_q[(int'(k)+1)*DATA_WIDTH +: DATA_WIDTH];
                            add_cin <= add_s[DATA_WIDTH];
                            state   <= ISSUE;
                        end else begin
                            bus.out_cout  <= add_s[DATA_WIDTH];
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ks_multiword_sequencer.sv
// Scoreboard bench for ks_multiword_sequencer with a two-register adder model.
// Subtract vectors run only when KS_MWSEQ_SUB_EN is defined.
module tb_ks_multiword_sequencer;
    localparam int DW    = 32;
    localparam int WORDS = 4;
    localparam int LAT   = 2;
    localparam int W     = DW * WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_cin;
    logic [DW:0]   add_s;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          rc;

    ks_multiword_sequencer_if #(.DATA_WIDTH(DW), .WORDS(WORDS)) bus ();

    ks_multiword_sequencer #(.DATA_WIDTH(DW), .WORDS(WORDS), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s)
    );

    always #5 clk = ~clk;

    // Adder: input DFF stage then registered sum, sharing rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0; rb <= '0; rc <= 1'b0; add_s <= '0;
        end else begin
            ra    <= add_a;
            rb    <= add_b;
            rc    <= add_cin;
            add_s <= {1'b0, ra} + {1'b0, rb} + {{DW{1'b0}}, rc};
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int last_hs = 0;
    logic [W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            last_hs = cyc + 1;
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_result: got %h", {bus.out_cout, bus.out_sum});
            end else begin
                chk("result", {bus.out_cout, bus.out_sum}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic keep);
        int n = 0;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready 0 required 1");
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: out_valid 0 required 1", nm);
        end
    endtask

    initial begin
        logic [W:0] held;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", W'(bus.in_ready), 1);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_add", {add_cin, add_a, add_b}, 0);
        chk("rst_out", {bus.out_cout, bus.out_sum}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full ripple: carry must propagate through all words.
        exp_q.push_back({1'b1, 128'h0});
        send({W{1'b1}}, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((cyc - acc_cyc) % 3 == 0 && cyc - acc_cyc > 0 && cyc - acc_cyc <= 9)
                chk("ripple_add_cin", W'(add_cin), 1);
        end
        wait_valid("ripple");

        // Single-word carry plus latency to out_valid.
        exp_q.push_back({1'b0, 128'h1_0000_0000});
        send(128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        wait_valid("latency");
        chk("latency_cycle", W'(cyc - acc_cyc + 1), 13);

        // Backpressure with a competing request during the stall.
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_q.push_back({1'b0, 128'h0000_0011_0000_0022_0000_0033_0000_0044});
        send(128'h0000_0001_0000_0002_0000_0003_0000_0004,
             128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        wait_valid("stall");
        held = {bus.out_cout, bus.out_sum};
        bus.in_a = 128'h99; bus.in_b = 128'h1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {bus.out_cout, bus.out_sum}, held);
            chk("stall_in_ready", W'(bus.in_ready), 0);
            chk("stall_valid", W'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", W'(bus.out_valid), 0);
        chk("release_in_ready", W'(bus.in_ready), 1);

        // Reset in cycle 6 discards the partial result.
        send({W{1'b1}}, 128'h1, 1'b0, 1'b0, 1'b0);
        while (cyc - acc_cyc < 5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", W'(bus.out_valid), 0);
        chk("midrst_in_ready", W'(bus.in_ready), 1);
        chk("midrst_add", {add_cin, add_a, add_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b0, 128'hC});
        send(128'h5, 128'h7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        wait_valid("after_rst");
        @(negedge clk);

`ifdef KS_MWSEQ_SUB_EN
        exp_q.push_back({1'b0, {{(W-2){1'b1}}, 2'b10}});
        send(128'h5, 128'h7, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        wait_valid("sub_borrow");
        @(negedge clk);
        exp_q.push_back({1'b1, 128'h2});
        send(128'h7, 128'h5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        wait_valid("sub_noborrow");
        @(negedge clk);
`else
        exp_q.push_back({1'b0, 128'hC});
        send(128'h5, 128'h7, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        wait_valid("sub_ignored");
        @(negedge clk);
`endif

        // Back-to-back with in_valid held high.
        exp_q.push_back({1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000});
        exp_q.push_back({1'b1, 128'h1});
        send(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 1'b1);
        send(128'h8000_0000_0000_0000_0000_0000_0000_0000,
             128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        chk("b2b_turnaround", W'(acc_cyc - last_hs), 1);
        @(negedge clk);
        wait_valid("b2b");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
